// File: rtl/maple_frame_tx.sv
// Maple bus frame transmitter: start pattern, LEN FIFO bytes, end pattern.
// Define MAPLE_TX_CRC_APPEND_EN to append an XOR checksum byte after the data.
module maple_frame_tx #(
    parameter int TICK_DIV     = 4,
    parameter int START_PULSES = 4,
    parameter int END_PULSES   = 2,
    parameter int LEN_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd,
    output logic             sdcka,
    output logic             sdckb
);
    localparam int START_STEPS = 1 + 2 * START_PULSES;
    localparam int END_STEPS   = 2 + 2 * END_PULSES;
    localparam int MAX_A       = (START_STEPS > 16) ? START_STEPS : 16;
    localparam int STEP_MAX    = (END_STEPS > MAX_A) ? END_STEPS : MAX_A;
    localparam int STEP_W      = $clog2(STEP_MAX);
    localparam int TICK_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END
`ifdef MAPLE_TX_CRC_APPEND_EN
        , S_CRC
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d, last_step;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ur_q, ur_d;
    logic               rd_q, rd_d;
    logic [1:0]         lines_q;
`ifdef MAPLE_TX_CRC_APPEND_EN
    logic [7:0]         crc_q, crc_d;
`endif

    // Line pattern {a, b} for a given state/step; data bits go MSB first.
    function automatic logic [1:0] lines_f(state_t s, logic [STEP_W-1:0] st,
                                           logic [7:0] b);
        logic [1:0] r;
        logic [2:0] k;
        logic       bv;
        r  = 2'b11;
        k  = st[3:1];
        bv = b[3'd7 - k];
        case (s)
            S_START: r = (st == '0) ? 2'b01 : {1'b0, ~st[0]};
            S_DATA:  r = k[0] ? {bv, ~st[0]} : {~st[0], bv};
`ifdef MAPLE_TX_CRC_APPEND_EN
            S_CRC:   r = k[0] ? {bv, ~st[0]} : {~st[0], bv};
`endif
            S_END: begin
                if (st == '0)
                    r = 2'b10;
                else if (st == STEP_W'(END_STEPS - 1))
                    r = 2'b11;
                else
                    r = {~st[0], 1'b0};
            end
            default: r = 2'b11;
        endcase
        return r;
    endfunction

    always_comb begin
        case (state_q)
            S_START: last_step = STEP_W'(START_STEPS - 1);
            S_END:   last_step = STEP_W'(END_STEPS - 1);
            default: last_step = STEP_W'(15);
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ur_d    = 1'b0;
        rd_d    = 1'b0;
`ifdef MAPLE_TX_CRC_APPEND_EN
        crc_d   = crc_q;
`endif
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_START;
                step_d  = '0;
                tick_d  = '0;
                cnt_d   = len;
                busy_d  = 1'b1;
`ifdef MAPLE_TX_CRC_APPEND_EN
                crc_d   = 8'h00;
`endif
            end
        end else if (tick_q != TICK_W'(TICK_DIV - 1)) begin
            tick_d = tick_q + TICK_W'(1);
        end else if (step_q != last_step) begin
            tick_d = '0;
            step_d = step_q + STEP_W'(1);
        end else begin
            tick_d = '0;
            step_d = '0;
            case (state_q)
                S_START, S_DATA: begin
                    // Byte fetch: decided here so the first step is registered with it.
                    if (cnt_q != '0) begin
                        if (fifo_empty) begin
                            ur_d    = 1'b1;
                            state_d = S_END;
                        end else begin
                            state_d = S_DATA;
                            byte_d  = fifo_data;
                            rd_d    = 1'b1;
                            cnt_d   = cnt_q - LEN_W'(1);
`ifdef MAPLE_TX_CRC_APPEND_EN
                            crc_d   = crc_q ^ fifo_data;
`endif
                        end
                    end else begin
`ifdef MAPLE_TX_CRC_APPEND_EN
                        state_d = S_CRC;
                        byte_d  = crc_q;
`else
                        state_d = S_END;
`endif
                    end
                end
`ifdef MAPLE_TX_CRC_APPEND_EN
                S_CRC: state_d = S_END;
`endif
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            tick_q  <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ur_q    <= 1'b0;
            rd_q    <= 1'b0;
            lines_q <= 2'b11;
`ifdef MAPLE_TX_CRC_APPEND_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ur_q    <= ur_d;
            rd_q    <= rd_d;
            lines_q <= lines_f(state_d, step_d, byte_d);
`ifdef MAPLE_TX_CRC_APPEND_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = ur_q;
    assign fifo_rd  = rd_q;
    assign sdcka    = lines_q[1];
    assign sdckb    = lines_q[0];
endmodule

// File: tb/tb_maple_frame_tx.sv
// Directed bench for maple_frame_tx: one TICK_DIV=1 instance with a FIFO
// model and one TICK_DIV=4 instance for step timing.
module tb_maple_frame_tx;
    localparam bit CRC =
`ifdef MAPLE_TX_CRC_APPEND_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [7:0] len1 = 8'd0, len4 = 8'd0;
    logic       busy1, done1, ur1, rd1, a1, b1;
    logic       busy4, done4, ur4, rd4, a4, b4;
    logic       fe1;
    logic [7:0] fd1;

    logic [7:0] mem [0:15];
    int         wp = 0;
    int         rp = 0;
    assign fe1 = (rp == wp);
    assign fd1 = mem[rp[3:0]];
    always @(posedge clk) if (rd1) rp <= rp + 1;

    maple_frame_tx #(.TICK_DIV(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .len(len1),
        .busy(busy1), .done(done1), .underrun(ur1),
        .fifo_empty(fe1), .fifo_data(fd1), .fifo_rd(rd1),
        .sdcka(a1), .sdckb(b1));

    maple_frame_tx #(.TICK_DIV(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .len(len4),
        .busy(busy4), .done(done4), .underrun(ur4),
        .fifo_empty(1'b1), .fifo_data(8'h00), .fifo_rd(rd4),
        .sdcka(a4), .sdckb(b4));

    logic [1:0] smp1 [0:127];
    int sn1 = 0, nrd1 = 0, ndone1 = 0, nur1 = 0;
    logic bp1 = 1'b0;
    always @(negedge clk) begin
        if (busy1) begin
            if (!bp1) sn1 = 0;
            if (sn1 < 128) smp1[sn1] = {a1, b1};
            sn1 = sn1 + 1;
        end
        bp1 = busy1;
        if (rd1) nrd1 = nrd1 + 1;
        if (done1) ndone1 = ndone1 + 1;
        if (ur1) nur1 = nur1 + 1;
    end

    logic [1:0] smp4 [0:15];
    int sn4 = 0, nf4 = 0, ndone4 = 0;
    logic bp4 = 1'b0, pb4 = 1'b1;
    always @(negedge clk) begin
        if (busy4) begin
            if (!bp4) begin
                sn4 = 0;
                nf4 = 0;
            end
            if (sn4 < 16) smp4[sn4] = {a4, b4};
            if (sn4 > 0 && sn4 < 36 && pb4 && !b4 && !a4) nf4 = nf4 + 1;
            sn4 = sn4 + 1;
        end
        bp4 = busy4;
        pb4 = b4;
        if (done4) ndone4 = ndone4 + 1;
    end

    int pass = 0, total = 0;
    int r0, d0, u0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total = total + 1;
        if (got === exp) pass = pass + 1;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] v);
        mem[wp[3:0]] = v;
        wp = wp + 1;
    endtask

    task automatic go1(input logic [7:0] l);
        @(posedge clk); #1;
        start1 = 1'b1;
        len1 = l;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        int d;
        d = ndone1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ndone1 != d) break;
        end
    endtask

    function automatic logic [7:0] dec(input int base);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++)
            r[7-k] = (k % 2 == 1) ? smp1[base+2*k][1] : smp1[base+2*k][0];
        return r;
    endfunction

    function automatic logic [31:0] pk(input int base, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++)
            r = (r << 2) | {30'd0, smp1[base+i]};
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_u1", {a1, b1, busy1, done1, ur1, rd1}, 6'b110000);
        chk("rst_u4", {a4, b4, busy4, done4, ur4, rd4}, 6'b110000);

        // 1) single byte 0xA5
        push(8'hA5);
        r0 = nrd1; d0 = ndone1; u0 = nur1;
        go1(8'd1);
        @(negedge clk); #1;
        chk("t1_busy_rise", busy1, 1);
        chk("t1_first_step", {a1, b1}, 2'b01);
        wait_done1(200);
        chk("t1_idle", {busy1, a1, b1}, 3'b011);
        chk("t1_cycles", sn1, CRC ? 47 : 31);
        chk("t1_rd", nrd1 - r0, 1);
        chk("t1_done", ndone1 - d0, 1);
        chk("t1_ur", nur1 - u0, 0);
        chk("t1_start_pat", pk(0, 9), 32'h11111);
        chk("t1_byte", dec(9), 8'hA5);
        chk("t1_bit01", pk(9, 4), 32'hD4);
        chk("t1_end_pat", pk(sn1 - 6, 6), 32'h88B);

        // 2) three bytes, checksum 0x70 when appended
        push(8'h12); push(8'h34); push(8'h56);
        r0 = nrd1; d0 = ndone1;
        go1(8'd3);
        wait_done1(300);
        chk("t2_cycles", sn1, CRC ? 79 : 63);
        chk("t2_rd", nrd1 - r0, 3);
        chk("t2_done", ndone1 - d0, 1);
        chk("t2_b0", dec(9), 8'h12);
        chk("t2_b1", dec(25), 8'h34);
        chk("t2_last", dec(sn1 - 22), CRC ? 8'h70 : 8'h56);
        chk("t2_end_pat", pk(sn1 - 6, 6), 32'h88B);

        // 3) underrun on second fetch
        push(8'h3C);
        r0 = nrd1; d0 = ndone1; u0 = nur1;
        go1(8'd2);
        wait_done1(300);
        chk("t3_cycles", sn1, 31);
        chk("t3_rd", nrd1 - r0, 1);
        chk("t3_ur", nur1 - u0, 1);
        chk("t3_done", ndone1 - d0, 1);
        chk("t3_byte", dec(9), 8'h3C);
        chk("t3_end_pat", pk(25, 6), 32'h88B);

        // 4) TICK_DIV=4 start pattern timing
        @(posedge clk); #1;
        start4 = 1'b1;
        len4 = 8'd0;
        @(posedge clk); #1;
        start4 = 1'b0;
        d0 = ndone4;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (ndone4 != d0) break;
        end
        chk("t4_done", ndone4 - d0, 1);
        chk("t4_falls", nf4, 4);
        chk("t4_cycles", sn4, CRC ? 124 : 60);
        chk("t4_hold", {smp4[3], smp4[4], smp4[7], smp4[8]}, 8'b01000001);

        // 5) reset during DATA, then a clean frame
        push(8'h81); push(8'h7E);
        d0 = ndone1;
        go1(8'd2);
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("t5_lines", {busy1, a1, b1}, 3'b011);
        repeat (40) @(negedge clk);
        #1;
        chk("t5_no_done", ndone1 - d0, 0);
        r0 = nrd1; d0 = ndone1;
        go1(8'd1);
        wait_done1(200);
        chk("t5_cycles", sn1, CRC ? 47 : 31);
        chk("t5_byte", dec(9), 8'h7E);
        chk("t5_rd", nrd1 - r0, 1);
        chk("t5_done", ndone1 - d0, 1);

        // 6) len=0 with start held during the frame
        r0 = nrd1; d0 = ndone1;
        @(posedge clk); #1;
        start1 = 1'b1;
        len1 = 8'd0;
        repeat (10) @(posedge clk);
        #1 start1 = 1'b0;
        wait_done1(200);
        chk("t6_cycles", sn1, CRC ? 31 : 15);
        chk("t6_rd", nrd1 - r0, 0);
        chk("t6_start_pat", pk(0, 9), 32'h11111);
        repeat (5) @(negedge clk);
        #1;
        chk("t6_idle", busy1, 0);
        chk("t6_done", ndone1 - d0, 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
